// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared AES types, S-box tables and GF(2^8) helpers for the iterative inverse cipher.
package aes_inv_cipher_iter_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned RND_W       = 4;

    // Byte 0 is the most significant byte of the 128-bit hex value (column 0, row 0).
    typedef logic [0:BLOCK_BYTES-1][BYTE_W-1:0] state_t;
    typedef logic [0:BLOCK_BYTES-1][BYTE_W-1:0] round_key_t;
    typedef logic [0:WORD_BYTES-1][BYTE_W-1:0]  word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant lookup; indices outside 1..10 never occur in ROUND and map to zero.
    function automatic logic [7:0] rcon_of(input logic [RND_W-1:0] idx);
        return (idx >= 4'd1 && idx <= 4'd10) ? RCON[idx] : 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] m;
        acc = '0;
        m   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ m;
            m = xtime(m);
        end
        return acc;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4'(r + 4*c)] = s[4'(r + 4*((c - r + 4) % 4))];
        return o;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++)
            o[4'(i)] = INV_SBOX[s[4'(i)]];
        return o;
    endfunction

    function automatic word_t sub_word(input word_t w);
        word_t o;
        for (int i = 0; i < 4; i++)
            o[2'(i)] = SBOX[w[2'(i)]];
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t     o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4'(4*c)];
            a1 = s[4'(4*c + 1)];
            a2 = s[4'(4*c + 2)];
            a3 = s[4'(4*c + 3)];
            o[4'(4*c)]     = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[4'(4*c + 1)] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[4'(4*c + 2)] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[4'(4*c + 3)] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One backwards step of the AES-128 key schedule: K_(i+1) and Rcon[i+1] in, K_i out.
module aes_inv_key_step
    import aes_inv_cipher_iter_pkg::*;
(
    input  round_key_t next_key,
    input  logic [7:0] rcon,
    output round_key_t prev_key
);

    word_t w0, w1, w2, w3;
    word_t p3, rot;

    // Undo the forward word chaining, then recover word 0 through SubWord/RotWord of the new last word.
    always_comb begin
        w0       = next_key[0:3];
        w1       = next_key[4:7];
        w2       = next_key[8:11];
        w3       = next_key[12:15];
        p3       = w3 ^ w2;
        rot      = {p3[1], p3[2], p3[3], p3[0]};
        prev_key = {w0 ^ sub_word(rot) ^ {rcon, 24'h000000}, w1 ^ w0, w2 ^ w1, p3};
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys regenerated backwards from K10.
module aes_inv_cipher_iter
    import aes_inv_cipher_iter_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  state_t     ciphertext,
    input  round_key_t key_last,
    output logic       out_valid,
    input  logic       out_ready,
    output state_t     plaintext
);

    fsm_state_t       fsm, fsm_next;
    state_t           state;
    round_key_t       rk;
    round_key_t       k_prev;
    logic [RND_W-1:0] rnd;
    state_t           t;
    logic             accept, step, finish, handoff;

    aes_inv_key_step u_key_step (
        .next_key (rk),
        .rcon     (rcon_of(rnd + 4'd1)),
        .prev_key (k_prev)
    );

    // Inverse round body shared by the middle rounds and the final round.
    always_comb begin
        t = inv_sub_bytes(inv_shift_rows(state)) ^ k_prev;
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) fsm <= IDLE;
        else          fsm <= fsm_next;
    end

    // Next-state and datapath control decode.
    always_comb begin
        fsm_next = fsm;
        in_ready = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        handoff  = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    fsm_next = ROUND;
                end
            end
            ROUND: begin
                if (rnd == '0) begin
                    finish   = 1'b1;
                    fsm_next = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    handoff  = 1'b1;
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // Block state, running round key, round counter and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= '0;
            rk        <= '0;
            rnd       <= '0;
            plaintext <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                state <= ciphertext ^ key_last;
                rk    <= key_last;
                rnd   <= RND_W'(NUM_ROUNDS - 1);
            end
            if (step) begin
                state <= inv_mix_columns(t);
                rk    <= k_prev;
                rnd   <= rnd - 4'd1;
            end
            if (finish) begin
                plaintext <= t;
                out_valid <= 1'b1;
            end
            if (handoff) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: known-answer vectors plus random blocks from a forward-AES model.
module tb_aes_inv_cipher_iter;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
    } vec_t;

    localparam int unsigned NVEC = 10;

    logic         clock, reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] ciphertext, key_last, plaintext;
    logic [127:0] ks_next, ks_prev;
    logic [7:0]   ks_rcon;

    int           n_cmp, n_bad;
    logic [7:0]   m_sbox [256];
    vec_t         vecs [NVEC];
    vec_t         vb, vc;
    int           n, hi_count, ridx;
    logic         take;
    int           acc_q [$];
    logic [127:0] out_q [$];
    logic [127:0] k0, pt_r, ct_r;

    aes_inv_cipher_iter #(.NUM_ROUNDS(10)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key_last   (key_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    aes_inv_key_step u_ks (
        .next_key (ks_next),
        .rcon     (ks_rcon),
        .prev_key (ks_prev)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: forward AES-128 from first principles ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'(9'h11b) << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] x, input int s);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < s; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] m_sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = m_mul(inv, x);
        return inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] m_rcon(input int i);
        logic [7:0] rc;
        rc = 8'h01;
        for (int j = 1; j < i; j++) rc = m_mul(rc, 8'h02);
        return rc;
    endfunction

    function automatic logic [127:0] m_round_key(input logic [127:0] key0, input int r);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = 32'(key0 >> (32 * (3 - i)));
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {m_sbox[tmp[31:24]], m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]]}
                      ^ {m_rcon(i / 4), 24'h000000};
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [127:0] p, input logic [127:0] key0);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rkey, o;
        for (int i = 0; i < 16; i++) s[i] = 8'(p >> (8 * (15 - i))) ^ 8'(key0 >> (8 * (15 - i)));
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) u[i] = m_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    s[rw + 4*c] = u[rw + 4*((c + rw) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
                    s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
                end
            end
            rkey = m_round_key(key0, r);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ 8'(rkey >> (8 * (15 - i)));
        end
        o = '0;
        for (int i = 0; i < 16; i++) o = (o << 8) | 128'(s[i]);
        return o;
    endfunction

    // ---------------- sequences ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_block(input vec_t v, input string name);
        int k;
        k = 0;
        while (!in_ready && k < 40) begin tick(); k++; end
        check({name, "_ready"}, 128'(in_ready), 128'(1));
        ciphertext = v.ct;
        key_last   = v.key;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        key_last   = {$urandom, $urandom, $urandom, $urandom};
        check({name, "_busy"}, 128'(in_ready), 128'(0));
        k = 0;
        while (!out_valid && k < 40) begin tick(); k++; end
        check({name, "_latency"}, 128'(k), 128'(10));
        check({name, "_pt"}, plaintext, v.pt);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_drop"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) m_sbox[i] = m_sbox_calc(8'(i));

        vb = '{128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
               128'h3243f6a8885a308d313198a2e0370734};
        vc = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5,
               128'h00112233445566778899aabbccddeeff};
        vecs[0] = vb;
        vecs[1] = vc;
        for (int i = 2; i < NVEC; i++) begin
            k0   = {$urandom, $urandom, $urandom, $urandom};
            pt_r = {$urandom, $urandom, $urandom, $urandom};
            ct_r = m_encrypt(pt_r, k0);
            vecs[i] = '{ct_r, m_round_key(k0, 10), pt_r};
        end

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ciphertext = '0;
        key_last   = '0;
        ks_next    = '0;
        ks_rcon    = '0;
        tick();
        tick();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_plaintext", plaintext, 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        reset_n = 1'b1;
        tick();

        // key step unit checks: FIPS K10 -> K9, then random rounds of random schedules
        ks_next = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        ks_rcon = 8'h36;
        #1;
        check("keystep_k9", ks_prev, 128'hac7766f319fadc2128d12941575c006e);
        for (int i = 0; i < 4; i++) begin
            k0      = {$urandom, $urandom, $urandom, $urandom};
            ridx    = int'($urandom_range(1, 10));
            ks_next = m_round_key(k0, ridx);
            ks_rcon = m_rcon(ridx);
            #1;
            check("keystep_rand", ks_prev, m_round_key(k0, ridx - 1));
        end

        // table-driven blocks
        for (int i = 0; i < NVEC; i++) run_block(vecs[i], $sformatf("vec%0d", i));

        // output backpressure with a stray in_valid pulse while DONE
        ciphertext = vc.ct;
        key_last   = vc.key;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        check("bp_latency", 128'(n), 128'(10));
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                in_valid   = 1'b1;
                ciphertext = vb.ct;
                key_last   = vb.key;
            end
            if (i == 6) in_valid = 1'b0;
            check("bp_valid_hold", 128'(out_valid), 128'(1));
            check("bp_pt_hold", plaintext, vc.pt);
            check("bp_ready_low", 128'(in_ready), 128'(0));
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 128'(out_valid), 128'(0));
        check("bp_idle", 128'(in_ready), 128'(1));
        hi_count = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) hi_count++;
        end
        check("bp_no_extra_block", 128'(hi_count), 128'(0));

        // back-to-back with in_valid and out_ready held high
        ciphertext = vb.ct;
        key_last   = vb.key;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            if (out_valid) out_q.push_back(plaintext);
            take = in_valid && in_ready;
            tick();
            if (take) begin
                acc_q.push_back(e);
                if (acc_q.size() == 1) begin
                    ciphertext = vc.ct;
                    key_last   = vc.key;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        check("b2b_accepts", 128'(acc_q.size()), 128'(2));
        check("b2b_spacing", 128'((acc_q.size() >= 2) ? (acc_q[1] - acc_q[0]) : 0), 128'(12));
        check("b2b_outputs", 128'(out_q.size()), 128'(2));
        check("b2b_pt0", (out_q.size() >= 1) ? out_q[0] : 128'(0), vb.pt);
        check("b2b_pt1", (out_q.size() >= 2) ? out_q[1] : 128'(0), vc.pt);

        // asynchronous reset at rnd = 5, then a clean C.1 decrypt
        ciphertext = vb.ct;
        key_last   = vb.key;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'(0));
        check("arst_plaintext", plaintext, 128'(0));
        check("arst_in_ready", 128'(in_ready), 128'(1));
        tick();
        reset_n = 1'b1;
        tick();
        run_block(vc, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

- Iterative AES-128 inverse cipher: turns one 128-bit ciphertext block into plaintext, one round per clock.
- Takes the last (round-10) round key and regenerates earlier round keys on the fly by running the key schedule backwards, so no key-expansion RAM is needed.
- Decrypt counterpart of the encrypt datapath; built on the shared AESDefinitions types and S-box tables.
- Valid/ready handshakes on input and output.

## Interface
Parameters:
- NUM_ROUNDS, 10, AES-128 round count; only 10 is supported.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  reset is asynchronous and active-low.
- in_valid  in  1  ciphertext and key_last are valid.
- in_ready  out  1  block can accept input; high only in IDLE.
- ciphertext  in  state_t (128)  input block; byte 0 = column 0, row 0.
- key_last  in  roundKey_t (128)  round-10 round key K10.
- out_valid  out  1  plaintext is valid.
- out_ready  in  1  consumer accepts plaintext.
- plaintext  out  state_t (128)  decrypted block.

## Operation
- FSM states: IDLE, ROUND, DONE.
- Byte index = row + 4*col. Key word w_i = bytes 4i..4i+3.
- **IDLE → ROUND** on in_valid && in_ready:
  - state ← ciphertext ^ key_last
  - rk ← key_last
  - rnd ← 9
- **ROUND**, each cycle:
  - Compute K_rnd from rk = K_(rnd+1), where p = previous key and w = current key:
    - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0
    - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[rnd+1],00,00,00}
    - RotWord[a0,a1,a2,a3] = [a1,a2,a3,a0]
    - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - t = InvSubBytes(InvShiftRows(state)) ^ K_rnd.
    - InvShiftRows: out[r+4c] = in[r+4((c−r) mod 4)].
    - InvSubBytes uses invSbox[b[7:4]][b[3:0]]; SubWord uses sbox likewise.
  - If rnd ≥ 1: state ← InvMixColumns(t), rk ← K_rnd, rnd ← rnd−1.
    - InvMixColumns uses GF(2^8) coefficients 0E,0B,0D,09 with polynomial 11B.
  - If rnd = 0: plaintext ← t, out_valid ← 1, go DONE.
- **DONE**:
  - Hold plaintext and out_valid stable until out_ready.
  - On out_valid && out_ready: out_valid ← 0, go IDLE.
- **Inputs while busy:** in_valid in ROUND or DONE is ignored because in_ready is low. The source must hold its data until it sees in_ready.
- **Reset:**
  - Reset in any state, including mid-round, immediately clears state, rk, rnd and plaintext to 0 and forces IDLE.
  - Reset values: out_valid 0, plaintext 0, in_ready 1 (IDLE).
  - A partially decrypted block is discarded; no output for it.
- **Width rules:** rnd is a 4-bit counter. All key and state arithmetic is bytewise XOR; no carries.

## Timing
- Accept edge is cycle 0. ROUND occupies cycles 1..10, with rnd = 9..0.
- out_valid rises at the edge ending cycle 10: latency is 10 cycles from the accept edge.
- in_ready is combinational from FSM state. out_valid and plaintext are registered.
- With out_ready held high:
  - DONE lasts 1 cycle, then IDLE 1 cycle.
  - A new accept is possible 12 cycles after the previous one.
- out_ready high while out_valid is low has no effect.

## Structure
- Additions to AESDefinitions:
  - Rcon table parameter (logic [1:10][7:0]).
  - Functions xtime, gmul, invShiftRows, invMixColumns.
  - FSM state enum.
- Reuse the package state_t, roundKey_t, sbox and invSbox.
- One sub-module: aes_inv_key_step.
  - Combinational: inputs K_(i+1) and Rcon[i+1]; output K_i.
  - Instantiated once.
- All registers live in aes_inv_cipher_iter.

## Test plan
- **FIPS-197 App. B:** key_last d014f9a8c9ee2589e13f0cc8b6630ca6, ciphertext 3925841d02dc09fbdc118597196a0b32 → plaintext 3243f6a8885a308d313198a2e0370734, with out_valid exactly 10 cycles after accept.
- **FIPS-197 C.1:** key_last 13111d7fe3944a17f307a78b4d2b30c5, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → plaintext 00112233445566778899aabbccddeeff.
- **Output backpressure:** hold out_ready low 20 cycles after out_valid → plaintext and out_valid stay stable, in_ready stays 0, and a second in_valid pulse is not accepted.
- **Back-to-back:** two blocks (B then C.1) with in_valid and out_ready held high → both plaintexts correct, in order, accepts 12 cycles apart.
- **Reset mid-operation:** assert reset_n low at rnd = 5 → asynchronously out_valid 0, plaintext 0, in_ready 1. After release, the C.1 vector decrypts correctly.
- **Key step unit check:** aes_inv_key_step with K10 d014f9a8c9ee2589e13f0cc8b6630ca6 and Rcon[10] = 36 → ac7766f319fadc2128d12941575c006e (K9).
